// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch types: datapath width, bubble encoding, fetch FSM states and IF/ID entry.
package legv8_pkg;
  localparam int N = 64;
  localparam logic [31:0] NOP_INSTR = 32'h8B1F03FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [N-1:0]    pc;
    logic [31:0]     instr;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, load captures a new entry, otherwise holds.
module if_id_reg #(
  parameter logic [31:0] NOP = legv8_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      flush,
  input  logic [legv8_pkg::N-1:0]   ld_pc,
  input  logic [31:0]               ld_instr,
  output logic                      valid,
  output logic [legv8_pkg::N-1:0]   pc,
  output logic [31:0]               instr
);
  import legv8_pkg::*;

  if_id_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d.valid = 1'b0;
      ent_d.instr = NOP;
    end else if (load) begin
      ent_d.valid = 1'b1;
      ent_d.pc    = ld_pc;
      ent_d.instr = ld_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q.valid <= 1'b0;
      ent_q.pc    <= '0;
      ent_q.instr <= NOP;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign valid = ent_q.valid;
  assign pc    = ent_q.pc;
  assign instr = ent_q.instr;
endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: PC, req/ack imem port, stall hold buffer and branch redirect/flush.
module fetch_stage #(
  parameter int          N         = legv8_pkg::N,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = 32'h8B1F03FF
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  input  logic [N-1:0] branch_target_i,
  output logic         if_id_valid,
  output logic [N-1:0] if_id_pc,
  output logic [31:0]  if_id_instr,
  output logic [10:0]  if_id_op
);
  import legv8_pkg::*;

  localparam logic [N-1:0] STEP       = N'(4);
  localparam logic [N-1:0] ALIGN_MASK = N'(3);

  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d, addr_q, addr_d;
  logic         req_q, req_d;
  logic [N-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [N-1:0] target, addr_inc, buf_inc;
  logic         ifid_load, ifid_flush;
  logic [N-1:0] ifid_ld_pc;
  logic [31:0]  ifid_ld_instr;

  assign target   = branch_target_i & ~ALIGN_MASK;
  assign addr_inc = addr_q + STEP;
  assign buf_inc  = buf_pc_q + STEP;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_ld_pc    = addr_q;
    ifid_ld_instr = imem_rdata;
    if (branch_taken_i) begin
      pc_d       = target;
      ifid_flush = 1'b1;
      // An unacknowledged request cannot be withdrawn, so it is drained in DROP.
      if ((state_q == FETCH || state_q == DROP) && !imem_ack) begin
        state_d = DROP;
      end else begin
        addr_d  = target;
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            if (stall_i) begin
              buf_pc_d    = addr_q;
              buf_instr_d = imem_rdata;
              state_d     = HOLD;
            end else begin
              ifid_load = 1'b1;
              pc_d      = addr_inc;
              addr_d    = addr_inc;
            end
          end else if (!stall_i) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_load     = 1'b1;
            ifid_ld_pc    = buf_pc_q;
            ifid_ld_instr = buf_instr_q;
            pc_d          = buf_inc;
            addr_d        = buf_inc;
            state_d       = FETCH;
          end
        end
        DROP: begin
          if (imem_ack) begin
            addr_d  = pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    req_d = (state_d == FETCH) || (state_d == DROP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  // Buffer contents only matter while in HOLD, so they need no reset.
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .ld_pc    (ifid_ld_pc),
    .ld_instr (ifid_ld_instr),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .instr    (if_id_instr)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_id_op  = if_id_instr[31:21];
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/branch/latency against a program-order model.
module tb_fetch_stage;
  localparam int N = 64;
  localparam logic [31:0] NOP = 32'h8B1F03FF;
  localparam logic [10:0] NOP_OP = 11'h458;

  logic         clk, reset, imem_req, imem_ack, stall_i, branch_taken_i, if_id_valid;
  logic [N-1:0] imem_addr, branch_target_i, if_id_pc;
  logic [31:0]  imem_rdata, if_id_instr;
  logic [10:0]  if_id_op;

  int total, bad, lat_mode, lat_cur, wait_cnt, n_cons;
  logic [N-1:0] exp_pc;

  fetch_stage #(.N(N), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_op        (if_id_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: low addresses hold LDUR-style words.
  function automatic logic [31:0] mem(input logic [N-1:0] a);
    if (a < 64'h40) return 32'hF8400000 | {11'd0, a[20:0]};
    return a[31:0] * 32'h9E3779B1 + 32'h01234567;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory/stall/branch at negedge, then check program order after the edge.
  task automatic cycle(input logic st, input logic br, input logic [N-1:0] tgt);
    logic         pv, preq, pack;
    logic [N-1:0] ppc, paddr;
    logic [31:0]  pin, w;
    logic [10:0]  pop;
    @(negedge clk);
    if (imem_req) begin
      if (wait_cnt == 0) lat_cur = (lat_mode < 0) ? int'($urandom_range(2, 0)) : lat_mode;
      pack = (wait_cnt >= lat_cur);
      wait_cnt = pack ? 0 : wait_cnt + 1;
    end else begin
      pack = 1'b0;
      wait_cnt = 0;
    end
    imem_ack        = pack;
    imem_rdata      = pack ? mem(imem_addr) : $urandom();
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = tgt;
    pv = if_id_valid; ppc = if_id_pc; pin = if_id_instr; pop = if_id_op;
    preq = imem_req; paddr = imem_addr;
    @(posedge clk);
    #1;
    if (pv && !st && !br) begin
      w = mem(exp_pc);
      chk("cons_pc", ppc, exp_pc);
      chk("cons_instr", pin, w);
      chk("cons_op", pop, w[31:21]);
      exp_pc = exp_pc + 64'd4;
      n_cons++;
    end
    if (br) begin
      exp_pc = tgt & ~64'h3;
      chk("flush_valid", if_id_valid, 1'b0);
    end else if (st) begin
      chk("stall_hold", {if_id_valid, if_id_pc, if_id_instr}, {pv, ppc, pin});
    end
    if (!if_id_valid) begin
      chk("inv_nop", if_id_instr, NOP);
      chk("inv_op", if_id_op, NOP_OP);
    end
    if (preq && !pack) begin
      chk("addr_stable", imem_addr, paddr);
      chk("req_held", imem_req, 1'b1);
    end
  endtask

  initial begin
    int k;
    int n0;
    total = 0; bad = 0; n_cons = 0; wait_cnt = 0; lat_cur = 0; lat_mode = 0; exp_pc = '0;
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_pc", if_id_pc, 64'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_op", if_id_op, NOP_OP);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle_req", imem_req, 1'b0);

    // Zero-wait memory: one instruction per cycle from RESET_PC.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0);
      chk("t1_pc", if_id_pc, 128'(4 * i));
      chk("t1_valid", if_id_valid, 1'b1);
      chk("t1_op", if_id_op, 11'h7C2);
    end

    // Two-cycle memory: bubble every other cycle, address held across the wait.
    lat_mode = 1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, '0);
      chk("t2_bubble", if_id_valid, 1'b0);
      chk("t2_addr_wait", imem_addr, 128'(16 + 4 * i));
      cycle(1'b0, 1'b0, '0);
      chk("t2_valid", if_id_valid, 1'b1);
      chk("t2_pc", if_id_pc, 128'(16 + 4 * i));
      chk("t2_addr_next", imem_addr, 128'(20 + 4 * i));
    end

    // Stall during an accepted fetch: IF/ID frozen, HOLD with no request.
    lat_mode = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0);
      chk("t3_frozen_pc", if_id_pc, 64'd20);
      chk("t3_frozen_valid", if_id_valid, 1'b1);
      chk("t3_hold_req", imem_req, 1'b0);
    end
    cycle(1'b0, 1'b0, '0);
    chk("t3_buf_pc", if_id_pc, 64'd24);
    chk("t3_buf_instr", if_id_instr, mem(64'd24));
    chk("t3_next_addr", imem_addr, 64'd28);
    chk("t3_req", imem_req, 1'b1);

    // Redirect with request outstanding: drain stale fetch, then fetch aligned target.
    lat_mode = 2;
    cycle(1'b0, 1'b1, 64'h103);
    chk("t4_flush_instr", if_id_instr, NOP);
    chk("t4_drop_req", imem_req, 1'b1);
    chk("t4_drop_addr", imem_addr, 64'd28);
    cycle(1'b0, 1'b0, '0);
    chk("t4_drop_wait", imem_addr, 64'd28);
    cycle(1'b0, 1'b0, '0);
    chk("t4_retarget", imem_addr, 64'h100);
    chk("t4_still_inv", if_id_valid, 1'b0);
    k = 0;
    while (!if_id_valid && k < 8) begin
      cycle(1'b0, 1'b0, '0);
      k++;
    end
    chk("t4_tgt_valid", if_id_valid, 1'b1);
    chk("t4_tgt_pc", if_id_pc, 64'h100);

    // Redirect and stall together: flush wins.
    lat_mode = 0;
    cycle(1'b1, 1'b1, 64'h2000);
    chk("t5_valid", if_id_valid, 1'b0);
    chk("t5_addr", imem_addr, 64'h2000);
    cycle(1'b0, 1'b0, '0);
    chk("t5_pc", if_id_pc, 64'h2000);

    // PC wraps modulo 2^N.
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 1'b0, '0);
    chk("wrap_top", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 1'b0, '0);
    chk("wrap_zero", if_id_pc, 64'h0);

    // Random latency, stalls and redirects.
    lat_mode = -1;
    n0 = n_cons;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 6,
            64'($urandom_range(4095, 0)));
    end
    chk("progress", (n_cons - n0) > 40, 1'b1);

    // Reset asserted during an outstanding request; ack around release ignored.
    lat_mode = 2;
    k = 0;
    while (!imem_req && k < 8) begin
      cycle(1'b0, 1'b0, '0);
      k++;
    end
    chk("t6_req_before", imem_req, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    stall_i = 1'b0;
    branch_taken_i = 1'b0;
    #1;
    chk("t6_req_drop", imem_req, 1'b0);
    chk("t6_addr", imem_addr, 64'h0);
    chk("t6_valid", if_id_valid, 1'b0);
    chk("t6_instr", if_id_instr, NOP);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("t6_rst_ack_ign", if_id_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_idle_ack_ign", if_id_valid, 1'b0);
    chk("t6_first_req", imem_req, 1'b1);
    chk("t6_first_addr", imem_addr, 64'h0);
    wait_cnt = 0;
    exp_pc = '0;
    lat_mode = 0;
    cycle(1'b0, 1'b0, '0);
    chk("t6_first_pc", if_id_pc, 64'h0);
    chk("t6_first_valid", if_id_valid, 1'b1);
    cycle(1'b0, 1'b0, '0);
    chk("t6_second_pc", if_id_pc, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
